// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- round-robin arbiter sharing one decoder slot between 8
// requesters. Grants are registered and held while the owner keeps
// requesting; a waiting requester forces rotation after MAX_HOLD cycles.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[7:0]   request vector, bit i = requester i
//   gnt[7:0]   one-hot grant, zero when gnt_valid=0
//   gnt_idx    index of current owner, zero when gnt_valid=0
//   gnt_valid  a grant is active (decoder enable)
//   preempt    one-cycle pulse on the first cycle of a forced rotation
//
// state | meaning
// IDLE  | no owner, waiting for any request
// GRANT | gnt_idx owns the slot, hold_cnt counts its tenure
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  // hold_cnt stops here; with preemption disabled it just saturates.
  localparam logic [7:0] HOLD_SAT   = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD - 1);
  localparam bit         PREEMPT_EN = (MAX_HOLD != 0);

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic [2:0] idx_nx;
  logic       valid_nx;
  logic       preempt_nx;
  logic [7:0] gnt_nx;
  logic [7:0] others;
  logic [2:0] next_ptr;

  // First asserted bit scanning s, s+1, ... wrapping 7->0. Callers only use
  // the result when v is non-zero.
  function automatic logic [2:0] search(input logic [7:0] v, input logic [2:0] s);
    logic [2:0] win;
    logic [2:0] j;
    win = s;
    for (int k = 7; k >= 0; k--) begin
      j = s + 3'(k);
      if (v[j]) win = j;
    end
    return win;
  endfunction

  assign others   = req & ~gnt;
  assign next_ptr = gnt_idx + 3'd1;

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    hold_nx    = hold_cnt;
    idx_nx     = gnt_idx;
    valid_nx   = gnt_valid;
    preempt_nx = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          idx_nx   = search(req, ptr);
          valid_nx = 1'b1;
          hold_nx  = 8'd0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          // Release wins over a coincident timeout: no preempt pulse.
          ptr_nx  = next_ptr;
          hold_nx = 8'd0;
          if (|others) begin
            idx_nx = search(others, next_ptr);
          end else begin
            idx_nx   = 3'd0;
            valid_nx = 1'b0;
            state_nx = IDLE;
          end
        end else if (PREEMPT_EN && (hold_cnt == HOLD_SAT) && (|others)) begin
          ptr_nx     = next_ptr;
          idx_nx     = search(others, next_ptr);
          hold_nx    = 8'd0;
          preempt_nx = 1'b1;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_nx = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 3'd0;
        valid_nx = 1'b0;
      end
    endcase
    gnt_nx = valid_nx ? (8'd1 << idx_nx) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= 8'd0;
      gnt       <= 8'd0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= idx_nx;
      gnt_valid <= valid_nx;
      preempt   <= preempt_nx;
    end
  end

endmodule
